// File: rtl/alu_multicycle_if.sv
// Valid/ready operation and result bundle between the ID/EXE register
// stage and the multicycle EXE ALU.
interface alu_multicycle_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carryIn;
  logic [3:0]   EXE_CMD;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic [3:0]   status;
  logic         busy;

  modport master (
    output in_valid, a, b, carryIn, EXE_CMD, out_ready,
    input  in_ready, out_valid, out, status, busy
  );

  modport slave (
    input  in_valid, a, b, carryIn, EXE_CMD, out_ready,
    output in_ready, out_valid, out, status, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered EXE-stage ALU: nine single-cycle EXE_CMD operations with NZCV
// status plus an iterative shift-add unsigned multiplier (MUL / UMULH).
module alu_multicycle #(
  parameter int N      = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [3:0] CMD_MOV   = 4'b0001;
  localparam logic [3:0] CMD_ADD   = 4'b0010;
  localparam logic [3:0] CMD_ADC   = 4'b0011;
  localparam logic [3:0] CMD_SUB   = 4'b0100;
  localparam logic [3:0] CMD_SBC   = 4'b0101;
  localparam logic [3:0] CMD_AND   = 4'b0110;
  localparam logic [3:0] CMD_ORR   = 4'b0111;
  localparam logic [3:0] CMD_EOR   = 4'b1000;
  localparam logic [3:0] CMD_MVN   = 4'b1001;
  localparam logic [3:0] CMD_MUL   = 4'b1010;
  localparam logic [3:0] CMD_UMULH = 4'b1011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           state_r;
  logic [N-1:0]     out_r;
  logic [3:0]       status_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [2*N-1:0]   acc_r;
  logic [N-1:0]     mcand_r;
  logic [N-1:0]     mplier_r;
  logic [CW-1:0]    cnt_r;
  logic             high_r;

  logic             in_ready_s;
  logic             accept_s;
  logic             start_mul_s;
  logic [N:0]       wide_s;
  logic [N-1:0]     alu_out_s;
  logic             c_s;
  logic             v_s;
  logic [3:0]       alu_status_s;
  logic [N:0]       step_sum_s;
  logic [2*N-1:0]   acc_next_s;
  logic [N-1:0]     mul_out_s;

  assign in_ready_s  = (state_r == IDLE) && (!out_valid_r || bus.out_ready);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign start_mul_s = (MUL_EN == 1'b1) &&
                       ((bus.EXE_CMD == CMD_MUL) || (bus.EXE_CMD == CMD_UMULH));

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
  assign bus.status    = status_r;
  assign bus.busy      = busy_r;

  // Single-cycle result and flags; arithmetic runs in N+1 bits so bit N is C.
  always_comb begin
    wide_s    = {(N+1){1'b0}};
    alu_out_s = {N{1'b0}};
    c_s       = 1'b0;
    v_s       = 1'b0;
    case (bus.EXE_CMD)
      CMD_MOV: alu_out_s = bus.b;
      CMD_MVN: alu_out_s = ~bus.b;
      CMD_ADD, CMD_ADC: begin
        if (bus.EXE_CMD == CMD_ADC) begin
          wide_s = {1'b0, bus.a} + {1'b0, bus.b} + {{N{1'b0}}, bus.carryIn};
        end else begin
          wide_s = {1'b0, bus.a} + {1'b0, bus.b};
        end
        alu_out_s = wide_s[N-1:0];
        c_s       = wide_s[N];
        v_s       = (bus.a[N-1] == bus.b[N-1]) && (wide_s[N-1] != bus.a[N-1]);
      end
      CMD_SUB, CMD_SBC: begin
        if (bus.EXE_CMD == CMD_SBC) begin
          wide_s = {1'b0, bus.a} - {1'b0, bus.b} - {{N{1'b0}}, ~bus.carryIn};
        end else begin
          wide_s = {1'b0, bus.a} - {1'b0, bus.b};
        end
        alu_out_s = wide_s[N-1:0];
        c_s       = wide_s[N];
        v_s       = (bus.a[N-1] != bus.b[N-1]) && (wide_s[N-1] != bus.a[N-1]);
      end
      CMD_AND: alu_out_s = bus.a & bus.b;
      CMD_ORR: alu_out_s = bus.a | bus.b;
      CMD_EOR: alu_out_s = bus.a ^ bus.b;
      default: alu_out_s = {N{1'b0}};
    endcase
    alu_status_s = {alu_out_s[N-1], (alu_out_s == {N{1'b0}}), c_s, v_s};
  end

  // One shift-add step; the add carry becomes the new top accumulator bit.
  always_comb begin
    if (mplier_r[0]) begin
      step_sum_s = {1'b0, acc_r[2*N-1:N]} + {1'b0, mcand_r};
    end else begin
      step_sum_s = {1'b0, acc_r[2*N-1:N]};
    end
    acc_next_s = {step_sum_s, acc_r[N-1:1]};
    if (high_r) begin
      mul_out_s = acc_next_s[2*N-1:N];
    end else begin
      mul_out_s = acc_next_s[N-1:0];
    end
  end

  // Control FSM, multiplier datapath and registered result/status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      out_r       <= {N{1'b0}};
      status_r    <= 4'b0000;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      acc_r       <= {(2*N){1'b0}};
      mcand_r     <= {N{1'b0}};
      mplier_r    <= {N{1'b0}};
      cnt_r       <= {CW{1'b0}};
      high_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && start_mul_s) begin
            state_r     <= MUL;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
            acc_r       <= {(2*N){1'b0}};
            mcand_r     <= bus.a;
            mplier_r    <= bus.b;
            cnt_r       <= {CW{1'b0}};
            high_r      <= (bus.EXE_CMD == CMD_UMULH);
          end else if (accept_s) begin
            out_r       <= alu_out_s;
            status_r    <= alu_status_s;
            out_valid_r <= 1'b1;
          end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        MUL: begin
          acc_r    <= acc_next_s;
          mplier_r <= mplier_r >> 1;
          if (cnt_r == CW'(N - 1)) begin
            out_r       <= mul_out_s;
            status_r    <= {mul_out_s[N-1], (mul_out_s == {N{1'b0}}), 2'b00};
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Randomised and directed check of alu_multicycle against an arithmetic
// reference model; a second instance covers the MUL_EN=0 build.
module tb_alu_multicycle;
  localparam int N = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  bit   nm_busy_seen;

  alu_multicycle_if #(.N(N)) bus ();
  alu_multicycle_if #(.N(N)) bus2 ();

  alu_multicycle #(.N(N), .MUL_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));
  alu_multicycle #(.N(N), .MUL_EN(1'b0)) dut_nm (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus2.busy === 1'b1) nm_busy_seen = 1'b1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Returns {N,Z,C,V, result} computed from integer arithmetic on the operands.
  function automatic logic [35:0] ref_alu(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin, input bit mul_en);
    longint ua, ub, sa, sb, u, s, extra;
    logic [63:0] prod;
    logic [31:0] r;
    logic c, v;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    prod = {32'd0, a} * {32'd0, b};
    r = 32'd0; c = 1'b0; v = 1'b0; u = 0; s = 0; extra = 0;
    case (cmd)
      4'd1: r = b;
      4'd9: r = ~b;
      4'd2, 4'd3: begin
        extra = (cmd == 4'd3) ? longint'(cin) : 0;
        u = ua + ub + extra;
        s = sa + sb + extra;
        r = u[31:0];
        c = (u >= 64'sd4294967296);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        extra = (cmd == 4'd5 && cin == 1'b0) ? 1 : 0;
        u = ua - ub - extra;
        s = sa - sb - extra;
        r = u[31:0];
        c = (u < 0);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: r = a & b;
      4'd7: r = a | b;
      4'd8: r = a ^ b;
      4'd10: r = mul_en ? prod[31:0] : 32'd0;
      4'd11: r = mul_en ? prod[63:32] : 32'd0;
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Presents one op, waits for acceptance, then checks latency, result and status.
  task automatic run_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input string tag);
    logic [35:0] exp;
    int guard, k, busy_cnt, rdy_bad;
    exp = ref_alu(cmd, a, b, cin, 1'b1);
    bus.a = a; bus.b = b; bus.carryIn = cin; bus.EXE_CMD = cmd; bus.in_valid = 1'b1;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) begin
      chk_eq({tag, "_accept_timeout"}, 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (cmd == 4'd10 || cmd == 4'd11) begin
      k = 0; busy_cnt = 0; rdy_bad = 0;
      while (bus.out_valid !== 1'b1 && k < 200) begin
        if (bus.busy === 1'b1) busy_cnt++;
        if (bus.in_ready !== 1'b0) rdy_bad++;
        @(posedge clk); #1;
        k++;
      end
      chk_eq({tag, "_mul_latency"}, 64'(k), 64'(N));
      chk_eq({tag, "_mul_busy_cycles"}, 64'(busy_cnt), 64'(N));
      chk_eq({tag, "_mul_ready_low"}, 64'(rdy_bad), 64'd0);
      chk_eq({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    end else begin
      chk_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    end
    chk_eq({tag, "_out"}, 64'(bus.out), 64'(exp[31:0]));
    chk_eq({tag, "_status"}, 64'(bus.status), 64'(exp[35:32]));
  endtask

  task automatic run_nm(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [35:0] exp;
    exp = ref_alu(cmd, a, b, 1'b0, 1'b0);
    bus2.a = a; bus2.b = b; bus2.carryIn = 1'b0; bus2.EXE_CMD = cmd; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk_eq({tag, "_valid"}, 64'(bus2.out_valid), 64'd1);
    chk_eq({tag, "_out"}, 64'(bus2.out), 64'(exp[31:0]));
    chk_eq({tag, "_status"}, 64'(bus2.status), 64'(exp[35:32]));
  endtask

  initial begin
    logic [3:0]  cmd;
    logic [31:0] ra, rb, add_res;
    n_cmp = 0; n_err = 0; nm_busy_seen = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = 32'd0; bus.b = 32'd0; bus.carryIn = 1'b0;
    bus.EXE_CMD = 4'd0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = 32'd0; bus2.b = 32'd0; bus2.carryIn = 1'b0;
    bus2.EXE_CMD = 4'd0; bus2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_out", 64'(bus.out), 64'd0);
    chk_eq("rst_status", 64'(bus.status), 64'd0);
    chk_eq("rst_valid", 64'(bus.out_valid), 64'd0);
    chk_eq("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    #1;
    chk_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, "add_ovf");
    chk_eq("add_ovf_const", 64'({bus.status, bus.out}), 64'h9_8000_0000);
    run_op(4'b0100, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub_borrow");
    chk_eq("sub_borrow_const", 64'({bus.status, bus.out}), 64'hA_FFFF_FFFF);
    run_op(4'b0101, 32'h0000_0005, 32'h0000_0003, 1'b0, "sbc");
    chk_eq("sbc_const", 64'({bus.status, bus.out}), 64'h0_0000_0001);
    run_op(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b0, "mul");
    chk_eq("mul_const", 64'({bus.status, bus.out}), 64'h4_0000_0000);
    run_op(4'b1011, 32'h0001_0000, 32'h0001_0000, 1'b0, "umulh");
    chk_eq("umulh_const", 64'({bus.status, bus.out}), 64'h0_0000_0001);
    run_op(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "unknown");
    chk_eq("unknown_const", 64'({bus.status, bus.out}), 64'h4_0000_0000);

    // Back-to-back single-cycle ops with out_ready high: no bubble.
    bus.a = 32'd10; bus.b = 32'd20; bus.carryIn = 1'b0; bus.EXE_CMD = 4'b0010;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk_eq("b2b_first", 64'(bus.out), 64'd30);
    bus.EXE_CMD = 4'b0110; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00;
    chk_eq("b2b_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_eq("b2b_second", 64'(bus.out), 64'hF000_F000);
    chk_eq("b2b_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    chk_eq("drain_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: a held ADD result blocks the EOR until it is consumed.
    bus.out_ready = 1'b0;
    run_op(4'b0010, 32'h0000_1111, 32'h0000_2222, 1'b0, "bp_add");
    add_res = 32'h0000_3333;
    bus.a = 32'hAAAA_0000; bus.b = 32'h5555_FFFF; bus.EXE_CMD = 4'b1000; bus.in_valid = 1'b1;
    #1;
    chk_eq("bp_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk_eq("bp_hold_out", 64'(bus.out), 64'(add_res));
    chk_eq("bp_hold_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    #1;
    chk_eq("bp_ready_high", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_eq("bp_eor_out", 64'(bus.out), 64'hFFFF_FFFF);
    chk_eq("bp_eor_status", 64'(bus.status), 64'h8);
    chk_eq("bp_eor_valid", 64'(bus.out_valid), 64'd1);

    // Randomised ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      cmd = 4'($urandom_range(0, 15));
      ra = pick();
      rb = pick();
      run_op(cmd, ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_c%0d", i, cmd));
    end

    // MUL_EN=0 build: multiply codes fall back to unknown-command behaviour.
    run_nm(4'b1010, 32'h0001_0000, 32'h0001_0000, "nm_mul");
    run_nm(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "nm_umulh");
    run_nm(4'b1111, 32'h0000_0001, 32'h0000_0002, "nm_unknown");
    run_nm(4'b0011, 32'hFFFF_FFFF, 32'h0000_0000, "nm_adc");
    chk_eq("nm_busy_never", 64'(nm_busy_seen), 64'd0);

    // Reset in the middle of a multiply abandons it immediately.
    run_op(4'b0111, 32'h0000_00F0, 32'h0000_000F, 1'b0, "pre_rst");
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_0003; bus.EXE_CMD = 4'b1010; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk_eq("rst_mid_busy_before", 64'(bus.busy), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_eq("rst_mid_busy", 64'(bus.busy), 64'd0);
    chk_eq("rst_mid_valid", 64'(bus.out_valid), 64'd0);
    chk_eq("rst_mid_out", 64'(bus.out), 64'd0);
    chk_eq("rst_mid_status", 64'(bus.status), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk_eq("rst_mid_no_result", 64'(bus.out_valid), 64'd0);
    run_op(4'b0001, 32'd0, 32'h0BAD_F00D, 1'b0, "post_rst_mov");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
